// File: rtl/csi_tx_lane_seq.sv
// csi_tx_lane_seq: byte-clock sequencer for one CSI-2 D-PHY transmit data lane.
// It walks LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trailer -> LP-11.
// All outputs except s_ready are registered from the state the FSM is leaving.
// As a result, every wire value shows up one byte clock after the state that
// produced it. In DATA this lines up exactly: a byte accepted in cycle k appears
// on hs_data in cycle k+1, and the sync byte directly precedes the payload.
module csi_tx_lane_seq #(
    parameter int unsigned T_LPX   = 2,
    parameter int unsigned T_PREP  = 2,
    parameter int unsigned T_ZERO  = 6,
    parameter int unsigned T_TRAIL = 3,
    parameter int unsigned T_EXIT  = 4,
    parameter bit          INVERT  = 1'b0
) (
    input  logic       byte_clock,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] hs_data,
    output logic       hs_en,
    output logic       lp_p,
    output logic       lp_n,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS_PREP,
        ST_HS_ZERO,
        ST_HS_SYNC,
        ST_DATA,
        ST_TRAIL
    } state_t;

    localparam logic [7:0] C_LPX      = 8'(T_LPX);
    localparam logic [7:0] C_PREP     = 8'(T_PREP);
    localparam logic [7:0] C_ZERO     = 8'(T_ZERO);
    localparam logic [7:0] C_TRAIL    = 8'(T_TRAIL);
    localparam logic [7:0] C_TRAIL_M1 = 8'(T_TRAIL - 1);
    localparam logic [7:0] C_EXIT     = 8'(T_EXIT);
    localparam logic [7:0] C_MASK     = {8{INVERT}};
    localparam logic [7:0] C_SYNC     = 8'hB8;

    state_t     r_state;
    logic [7:0] r_cnt;       // shared down-counter, terminal count is 1
    logic       r_b7;        // bit7 of the last byte put on the wire (sync counts)
    logic [7:0] r_hs_data;
    logic       r_hs_en;
    logic       r_lp_p;
    logic       r_lp_n;
    logic       r_busy;
    logic       r_underrun;

    logic       w_term;
    logic [7:0] w_trail;

    assign w_term  = (r_cnt == 8'd1);
    // The trailer repeats the complement of the final bit sent.
    assign w_trail = {8{~r_b7}} ^ C_MASK;

    assign s_ready  = (r_state == ST_DATA);
    assign hs_data  = r_hs_data;
    assign hs_en    = r_hs_en;
    assign lp_p     = r_lp_p;
    assign lp_n     = r_lp_n;
    assign busy     = r_busy;
    assign underrun = r_underrun;

    // Lane FSM: state, counter, and registered line outputs.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_STOP;
            r_cnt      <= C_EXIT;
            r_b7       <= 1'b1;
            r_hs_data  <= 8'h00;
            r_hs_en    <= 1'b0;
            r_lp_p     <= 1'b1;
            r_lp_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    r_hs_data <= 8'h00;
                    r_hs_en   <= 1'b0;
                    r_lp_p    <= 1'b1;
                    r_lp_n    <= 1'b1;
                    r_busy    <= 1'b0;
                    // The counter sits at 1 once the exit time has elapsed.
                    if (s_valid && w_term) begin
                        r_state <= ST_HS_RQST;
                        r_cnt   <= C_LPX;
                    end else if (!w_term) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HS_RQST: begin
                    r_hs_data <= 8'h00;
                    r_hs_en   <= 1'b0;
                    r_lp_p    <= 1'b0;
                    r_lp_n    <= 1'b1;
                    r_busy    <= 1'b1;
                    if (w_term) begin
                        r_state <= ST_HS_PREP;
                        r_cnt   <= C_PREP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HS_PREP: begin
                    r_hs_data <= 8'h00;
                    r_hs_en   <= 1'b0;
                    r_lp_p    <= 1'b0;
                    r_lp_n    <= 1'b0;
                    r_busy    <= 1'b1;
                    if (w_term) begin
                        r_state <= ST_HS_ZERO;
                        r_cnt   <= C_ZERO;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HS_ZERO: begin
                    r_hs_data <= C_MASK;
                    r_hs_en   <= 1'b1;
                    r_lp_p    <= 1'b0;
                    r_lp_n    <= 1'b0;
                    r_busy    <= 1'b1;
                    if (w_term) begin
                        r_state <= ST_HS_SYNC;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HS_SYNC: begin
                    r_hs_data <= C_SYNC ^ C_MASK;
                    r_hs_en   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_b7      <= C_SYNC[7];
                    r_state   <= ST_DATA;
                end
                ST_DATA: begin
                    r_hs_en <= 1'b1;
                    r_busy  <= 1'b1;
                    if (s_valid) begin
                        r_hs_data <= s_data ^ C_MASK;
                        r_b7      <= s_data[7];
                        if (s_last) begin
                            r_state <= ST_TRAIL;
                            r_cnt   <= C_TRAIL;
                        end
                    end else begin
                        // Starved: the first trailer byte goes out now so the
                        // wire stays contiguous and still carries T_TRAIL bytes.
                        r_hs_data  <= w_trail;
                        r_underrun <= 1'b1;
                        if (C_TRAIL_M1 == 8'd0) begin
                            r_state <= ST_STOP;
                            r_cnt   <= C_EXIT;
                        end else begin
                            r_state <= ST_TRAIL;
                            r_cnt   <= C_TRAIL_M1;
                        end
                    end
                end
                ST_TRAIL: begin
                    r_hs_data <= w_trail;
                    r_hs_en   <= 1'b1;
                    r_busy    <= 1'b1;
                    if (w_term) begin
                        r_state <= ST_STOP;
                        r_cnt   <= C_EXIT;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_STOP;
                    r_cnt   <= C_EXIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi_tx_lane_seq.sv
// Bench for csi_tx_lane_seq: a normal and an inverted lane share stimulus.
// The captured wire sequence is checked against a per-burst line-state model.
`timescale 1ns/1ps
module tb_csi_tx_lane_seq;

    localparam int T_LPX   = 2;
    localparam int T_PREP  = 2;
    localparam int T_ZERO  = 6;
    localparam int T_TRAIL = 3;
    localparam int T_EXIT  = 4;

    typedef logic [12:0] smp_t;   // {underrun, busy, hs_en, lp_p, lp_n, hs_data}
    typedef smp_t        sq_t[$];
    typedef logic [7:0]  bq_t[$];
    typedef bit          lq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;

    logic       s_ready0, hs_en0, lp_p0, lp_n0, busy0, underrun0;
    logic [7:0] hs0;
    logic       s_ready1, hs_en1, lp_p1, lp_n1, busy1, underrun1;
    logic [7:0] hs1;

    int   errors = 0;
    int   checks = 0;
    sq_t  cap0, cap1;
    int   idle_cnt, acc_cnt, rdy_cnt;

    always #5 clk = ~clk;

    csi_tx_lane_seq #(.T_LPX(T_LPX), .T_PREP(T_PREP), .T_ZERO(T_ZERO), .T_TRAIL(T_TRAIL),
                      .T_EXIT(T_EXIT), .INVERT(1'b0)) u_dut0 (
        .byte_clock(clk), .reset_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready0), .hs_data(hs0), .hs_en(hs_en0), .lp_p(lp_p0), .lp_n(lp_n0),
        .busy(busy0), .underrun(underrun0));

    csi_tx_lane_seq #(.T_LPX(T_LPX), .T_PREP(T_PREP), .T_ZERO(T_ZERO), .T_TRAIL(T_TRAIL),
                      .T_EXIT(T_EXIT), .INVERT(1'b1)) u_dut1 (
        .byte_clock(clk), .reset_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready1), .hs_data(hs1), .hs_en(hs_en1), .lp_p(lp_p1), .lp_n(lp_n1),
        .busy(busy1), .underrun(underrun1));

    function automatic smp_t pk(input bit u, input bit b, input bit en, input bit p, input bit n,
                                input logic [7:0] d);
        return {u, b, en, p, n, d};
    endfunction

    // Expected wire, one entry per byte clock, from the first LP-01 cycle of a
    // burst through the minimum LP-11 gap that follows it.
    function automatic sq_t burst(input bq_t pay, input bit under, input bit inv);
        sq_t        e;
        logic [7:0] m, t;
        bit         b7;
        m = inv ? 8'hFF : 8'h00;
        for (int i = 0; i < T_LPX; i++)  e.push_back(pk(0, 1, 0, 0, 1, 8'h00));
        for (int i = 0; i < T_PREP; i++) e.push_back(pk(0, 1, 0, 0, 0, 8'h00));
        for (int i = 0; i < T_ZERO; i++) e.push_back(pk(0, 1, 1, 0, 0, m));
        e.push_back(pk(0, 1, 1, 0, 0, 8'hB8 ^ m));
        b7 = 1'b1;
        foreach (pay[i]) begin
            e.push_back(pk(0, 1, 1, 0, 0, pay[i] ^ m));
            b7 = pay[i][7];
        end
        t = (b7 ? 8'h00 : 8'hFF) ^ m;
        for (int i = 0; i < T_TRAIL; i++) e.push_back(pk(under && (i == 0), 1, 1, 0, 0, t));
        for (int i = 0; i < T_EXIT; i++) e.push_back(pk(0, 0, 0, 1, 1, 8'h00));
        return e;
    endfunction

    // Offers bytes d[0..nsend-1] and records ncyc cycles starting at the first LP-01.
    task automatic run(input bq_t d, input lq_t lst, input int nsend, input int ncyc);
        cap0 = {}; cap1 = {};
        idle_cnt = 0; acc_cnt = 0; rdy_cnt = 0;
        fork
            begin
                int idx = 0;
                int g = 0;
                bit hsk;
                while (idx < nsend && g < 300) begin
                    s_valid = 1'b1; s_data = d[idx]; s_last = lst[idx];
                    @(negedge clk); hsk = s_ready0;
                    @(posedge clk); #1;
                    if (hsk) idx++;
                    g++;
                end
                s_valid = 1'b0; s_last = 1'b0;
            end
            begin
                int g = 0;
                bit seen = 0;
                while (!seen && g < 200) begin
                    @(negedge clk);
                    if (s_valid && s_ready0) acc_cnt++;
                    if (!lp_p0 && lp_n0) seen = 1;
                    else begin idle_cnt++; g++; end
                end
                if (seen) begin
                    cap0.push_back({underrun0, busy0, hs_en0, lp_p0, lp_n0, hs0});
                    cap1.push_back({underrun1, busy1, hs_en1, lp_p1, lp_n1, hs1});
                    while (cap0.size() < ncyc) begin
                        @(negedge clk);
                        if (s_valid && s_ready0) acc_cnt++;
                        if (s_ready0) rdy_cnt++;
                        cap0.push_back({underrun0, busy0, hs_en0, lp_p0, lp_n0, hs0});
                        cap1.push_back({underrun1, busy1, hs_en1, lp_p1, lp_n1, hs1});
                    end
                end
            end
        join
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({hs0, hs_en0, lp_p0, lp_n0, s_ready0, busy0, underrun0} !== {8'h00, 6'b011000}) begin
            errors++;
            $display("FAIL reset dut0 got hs=%h en=%b lp=%b%b rdy=%b busy=%b und=%b want 00 0 11 0 0 0",
                     hs0, hs_en0, lp_p0, lp_n0, s_ready0, busy0, underrun0);
        end
        checks++;
        if ({hs1, hs_en1, lp_p1, lp_n1, s_ready1, busy1, underrun1} !== {8'h00, 6'b011000}) begin
            errors++;
            $display("FAIL reset dut1 got hs=%h en=%b lp=%b%b rdy=%b busy=%b und=%b want 00 0 11 0 0 0",
                     hs1, hs_en1, lp_p1, lp_n1, s_ready1, busy1, underrun1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        bq_t d = '{8'h5A};
        lq_t l = '{1'b1};
        sq_t e0 = burst(d, 0, 0);
        sq_t e1 = burst(d, 0, 1);
        run(d, l, 1, e0.size());
        checks++;
        if (idle_cnt != T_EXIT) begin errors++; $display("FAIL single exit_gap got %0d want %0d", idle_cnt, T_EXIT); end
        checks++;
        if (acc_cnt != 1) begin errors++; $display("FAIL single accepts got %0d want 1", acc_cnt); end
        checks++;
        if (cap0.size() != e0.size()) begin errors++; $display("FAIL single len got %0d want %0d", cap0.size(), e0.size()); end
        for (int i = 0; i < e0.size() && i < cap0.size(); i++) begin
            checks += 2;
            if (cap0[i] !== e0[i]) begin errors++; $display("FAIL single dut0 cyc%0d got %h want %h", i, cap0[i], e0[i]); end
            if (cap1[i] !== e1[i]) begin errors++; $display("FAIL single dut1 cyc%0d got %h want %h", i, cap1[i], e1[i]); end
        end
    endtask

    task automatic test_multi;
        bq_t d = '{8'h01, 8'h80, 8'h33, 8'hC4};
        lq_t l = '{1'b0, 1'b0, 1'b0, 1'b1};
        sq_t e0 = burst(d, 0, 0);
        sq_t e1 = burst(d, 0, 1);
        run(d, l, 4, e0.size());
        checks++;
        if (acc_cnt != 4) begin errors++; $display("FAIL multi accepts got %0d want 4", acc_cnt); end
        checks++;
        if (rdy_cnt != 4) begin errors++; $display("FAIL multi ready_cycles got %0d want 4", rdy_cnt); end
        checks++;
        if (cap0.size() != e0.size()) begin errors++; $display("FAIL multi len got %0d want %0d", cap0.size(), e0.size()); end
        for (int i = 0; i < e0.size() && i < cap0.size(); i++) begin
            checks += 2;
            if (cap0[i] !== e0[i]) begin errors++; $display("FAIL multi dut0 cyc%0d got %h want %h", i, cap0[i], e0[i]); end
            if (cap1[i] !== e1[i]) begin errors++; $display("FAIL multi dut1 cyc%0d got %h want %h", i, cap1[i], e1[i]); end
        end
    endtask

    task automatic test_underrun;
        bq_t d = '{8'h11, 8'h92, 8'h5E, 8'h6F, 8'h70};
        lq_t l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bq_t sent = '{8'h11, 8'h92};
        sq_t e0 = burst(sent, 1, 0);
        sq_t e1 = burst(sent, 1, 1);
        int pulses = 0;
        run(d, l, 2, e0.size());
        foreach (cap0[i]) if (cap0[i][12]) pulses++;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL underrun pulses got %0d want 1", pulses); end
        checks++;
        if (acc_cnt != 2) begin errors++; $display("FAIL underrun accepts got %0d want 2", acc_cnt); end
        checks++;
        if (cap0.size() != e0.size()) begin errors++; $display("FAIL underrun len got %0d want %0d", cap0.size(), e0.size()); end
        for (int i = 0; i < e0.size() && i < cap0.size(); i++) begin
            checks += 2;
            if (cap0[i] !== e0[i]) begin errors++; $display("FAIL underrun dut0 cyc%0d got %h want %h", i, cap0[i], e0[i]); end
            if (cap1[i] !== e1[i]) begin errors++; $display("FAIL underrun dut1 cyc%0d got %h want %h", i, cap1[i], e1[i]); end
        end
    endtask

    task automatic test_invert;
        bq_t d = '{8'h00};
        lq_t l = '{1'b1};
        sq_t e0 = burst(d, 0, 0);
        sq_t e1 = burst(d, 0, 1);
        run(d, l, 1, e0.size());
        checks++;
        if (cap1.size() != e1.size()) begin errors++; $display("FAIL invert len got %0d want %0d", cap1.size(), e1.size()); end
        for (int i = 0; i < e1.size() && i < cap1.size(); i++) begin
            checks += 2;
            if (cap1[i] !== e1[i]) begin errors++; $display("FAIL invert dut1 cyc%0d got %h want %h", i, cap1[i], e1[i]); end
            if (cap0[i] !== e0[i]) begin errors++; $display("FAIL invert dut0 cyc%0d got %h want %h", i, cap0[i], e0[i]); end
        end
    endtask

    task automatic test_back_to_back;
        bq_t d  = '{8'hA7, 8'h3C, 8'h0F};
        lq_t l  = '{1'b0, 1'b1, 1'b1};
        bq_t b1 = '{8'hA7, 8'h3C};
        bq_t b2 = '{8'h0F};
        sq_t e0 = burst(b1, 0, 0);
        sq_t e1 = burst(b1, 0, 1);
        sq_t t0 = burst(b2, 0, 0);
        sq_t t1 = burst(b2, 0, 1);
        foreach (t0[i]) e0.push_back(t0[i]);
        foreach (t1[i]) e1.push_back(t1[i]);
        run(d, l, 3, e0.size());
        checks++;
        if (acc_cnt != 3) begin errors++; $display("FAIL b2b accepts got %0d want 3", acc_cnt); end
        checks++;
        if (cap0.size() != e0.size()) begin errors++; $display("FAIL b2b len got %0d want %0d", cap0.size(), e0.size()); end
        for (int i = 0; i < e0.size() && i < cap0.size(); i++) begin
            checks += 2;
            if (cap0[i] !== e0[i]) begin errors++; $display("FAIL b2b dut0 cyc%0d got %h want %h", i, cap0[i], e0[i]); end
            if (cap1[i] !== e1[i]) begin errors++; $display("FAIL b2b dut1 cyc%0d got %h want %h", i, cap1[i], e1[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bq_t d = '{8'h3C};
        lq_t l = '{1'b1};
        sq_t e0 = burst(d, 0, 0);
        sq_t e1 = burst(d, 0, 1);
        int g = 0;
        s_data = 8'h3C; s_last = 1'b1; s_valid = 1'b1;
        do begin @(negedge clk); g++; end while (!(!lp_p0 && lp_n0) && g < 200);
        checks++;
        if (g >= 200) begin errors++; $display("FAIL rstmid request got none want lp=01"); end
        // Land on the third HS-zero byte on the wire.
        repeat (T_LPX + T_PREP + 2) @(negedge clk);
        checks++;
        if ({hs_en0, hs0} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL rstmid pre got en=%b hs=%h want 1 00", hs_en0, hs0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hs_en0, lp_p0, lp_n0, s_ready0, busy0, hs0} !== {5'b01100, 8'h00}) begin
            errors++;
            $display("FAIL rstmid dut0 got en=%b lp=%b%b rdy=%b busy=%b hs=%h want 0 11 0 0 00",
                     hs_en0, lp_p0, lp_n0, s_ready0, busy0, hs0);
        end
        checks++;
        if ({hs_en1, lp_p1, lp_n1, s_ready1, busy1, hs1} !== {5'b01100, 8'h00}) begin
            errors++;
            $display("FAIL rstmid dut1 got en=%b lp=%b%b rdy=%b busy=%b hs=%h want 0 11 0 0 00",
                     hs_en1, lp_p1, lp_n1, s_ready1, busy1, hs1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(d, l, 1, e0.size());
        checks++;
        if (idle_cnt != T_EXIT) begin errors++; $display("FAIL rstmid exit_gap got %0d want %0d", idle_cnt, T_EXIT); end
        checks++;
        if (cap0.size() != e0.size()) begin errors++; $display("FAIL rstmid len got %0d want %0d", cap0.size(), e0.size()); end
        for (int i = 0; i < e0.size() && i < cap0.size(); i++) begin
            checks += 2;
            if (cap0[i] !== e0[i]) begin errors++; $display("FAIL rstmid dut0 cyc%0d got %h want %h", i, cap0[i], e0[i]); end
            if (cap1[i] !== e1[i]) begin errors++; $display("FAIL rstmid dut1 cyc%0d got %h want %h", i, cap1[i], e1[i]); end
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            bq_t d, sent;
            lq_t l;
            sq_t e0, e1;
            int  n = int'($urandom_range(1, 6));
            bit  under = bit'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                d.push_back(8'($urandom));
                sent.push_back(d[k]);
                l.push_back(!under && (k == n - 1));
            end
            d.push_back(8'($urandom));
            l.push_back(1'b1);
            e0 = burst(sent, under, 0);
            e1 = burst(sent, under, 1);
            run(d, l, n, e0.size());
            checks++;
            if (acc_cnt != n) begin errors++; $display("FAIL random%0d accepts got %0d want %0d", it, acc_cnt, n); end
            checks++;
            if (cap0.size() != e0.size()) begin errors++; $display("FAIL random%0d len got %0d want %0d", it, cap0.size(), e0.size()); end
            for (int i = 0; i < e0.size() && i < cap0.size(); i++) begin
                checks += 2;
                if (cap0[i] !== e0[i]) begin errors++; $display("FAIL random%0d dut0 cyc%0d got %h want %h", it, i, cap0[i], e0[i]); end
                if (cap1[i] !== e1[i]) begin errors++; $display("FAIL random%0d dut1 cyc%0d got %h want %h", it, i, cap1[i], e1[i]); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_underrun;
        test_invert;
        test_back_to_back;
        test_reset_mid;
        test_random;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
